// File: rtl/sha_pkg.sv
// Shared types, constants and SHA-256 message-schedule helpers for the
// byte-serial message schedule block.
package sha_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_ROUND
    } state_t;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int BYTES_PER_BLOCK = 64;
    localparam int ROUNDS          = 64;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_byte_packer.sv
// Packs big-endian message bytes into 32-bit words; word_valid marks the
// cycle in which the fourth byte of a word is presented.
module sha_byte_packer
    import sha_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] byte_in,
    output logic       word_valid,
    output word_t      word
);

    logic [1:0]  cnt_q;
    // Only the three leading bytes need storage; the fourth arrives live.
    logic [23:0] acc_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (byte_en) begin
            cnt_q <= cnt_q + 2'd1;
            acc_q <= {acc_q[15:0], byte_in};
        end
    end

    assign word       = {acc_q, byte_in};
    assign word_valid = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: loads one 64-byte block into a 16-word sliding
// window, then emits W[0..63] one word per round-enable cycle.
module sha_msg_schedule
    import sha_pkg::*;
#(
    parameter bit ERR_CHECK = 1'b1
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        load_ready,
    output logic        block_loaded,
    input  logic        round_en,
    input  logic [5:0]  round_idx,
    output logic [31:0] w_out,
    output logic        w_valid,
    output logic        seq_err
);

    state_t state_q, state_d;
    logic [5:0] byte_cnt_q;
    logic [5:0] rnd_cnt_q;
    word_t      window_q [WORDS_PER_BLOCK];
    logic       block_loaded_q;

    logic  accept;
    logic  last_byte;
    logic  advance;
    logic  word_valid;
    word_t packed_word;
    word_t sched_word;
    word_t new_word;
    logic  shift_en;

    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept     = byte_valid && load_ready && !flush;
    assign last_byte  = accept && (byte_cnt_q == 6'(BYTES_PER_BLOCK - 1));

    // The FULL cycle that first sees round_en is round 0, so a controller
    // holding round_en for 64 cycles consumes exactly 64 words.
    assign advance = round_en && !flush &&
                     ((state_q == ST_FULL) || (state_q == ST_ROUND));

    sha_byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (flush),
        .byte_en    (accept),
        .byte_in    (byte_in),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    assign sched_word = sigma1(window_q[14]) + window_q[9]
                      + sigma0(window_q[1]) + window_q[0];

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        new_word = sched_word;
        shift_en = 1'b0;
        if (word_valid) begin
            new_word = packed_word;
            shift_en = 1'b1;
        end else if (advance) begin
            shift_en = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept)    state_d = ST_LOAD;
                ST_LOAD:  if (last_byte) state_d = ST_FULL;
                ST_FULL:  if (advance)   state_d = ST_ROUND;
                ST_ROUND: if (advance && (rnd_cnt_q == 6'(ROUNDS - 1)))
                              state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            rnd_cnt_q      <= '0;
            block_loaded_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            block_loaded_q <= last_byte;
            if (flush) begin
                byte_cnt_q <= '0;
                rnd_cnt_q  <= '0;
            end else begin
                if (accept)  byte_cnt_q <= byte_cnt_q + 6'd1;
                if (advance) rnd_cnt_q  <= rnd_cnt_q + 6'd1;
            end
        end
    end

    // NOTE: the window is a small register file read combinationally at
    // reset exit (w_out), so it is cleared rather than left to power-up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) window_q[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) window_q[i] <= window_q[i + 1];
            window_q[WORDS_PER_BLOCK - 1] <= new_word;
        end
    end

    assign block_loaded = block_loaded_q;
    assign w_out        = window_q[0];
    assign w_valid      = advance;

    generate
        if (ERR_CHECK) begin : g_err
            logic seq_err_q;
            logic err_event;

            assign err_event = round_en && (
                (((state_q == ST_FULL) || (state_q == ST_ROUND)) && (round_idx != rnd_cnt_q)) ||
                (state_q == ST_IDLE) || (state_q == ST_LOAD));

            // Sticky until reset; flush deliberately leaves it set.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)          seq_err_q <= 1'b0;
                else if (err_event) seq_err_q <= 1'b1;
            end

            assign seq_err = seq_err_q;
        end else begin : g_no_err
            assign seq_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: golden W[t] model feeding a scoreboard
// queue that is drained whenever the DUT asserts w_valid.
module tb_sha_msg_schedule;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        load_ready;
    logic        block_loaded;
    logic        round_en;
    logic [5:0]  round_idx;
    logic [31:0] w_out;
    logic        w_valid;
    logic        seq_err;

    always #5 clk = ~clk;

    sha_msg_schedule #(.ERR_CHECK(1'b1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .load_ready   (load_ready),
        .block_loaded (block_loaded),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .w_out        (w_out),
        .w_valid      (w_valid),
        .seq_err      (seq_err)
    );

    logic [7:0]  msg    [64];
    logic [31:0] w_gold [64];
    logic [31:0] exp_q  [$];
    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [31:0] s0_m(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] s1_m(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ {10'b0, x[31:10]};
    endfunction

    task automatic compute_gold();
        for (int i = 0; i < 16; i++)
            w_gold[i] = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
        for (int i = 16; i < 64; i++)
            w_gold[i] = s1_m(w_gold[i-2]) + w_gold[i-7] + s0_m(w_gold[i-15]) + w_gold[i-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 64; i++) msg[i] = 8'h00;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h80;
        msg[63] = 8'h18;
        compute_gold();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(255, 0));
        compute_gold();
    endtask

    // Drives bytes 0..n-1; returns just after driving the last one.
    task automatic load_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = msg[i];
            #1;
            if (block_loaded) pulses++;
            check("load_ready_during_load", {31'b0, load_ready}, 32'd1);
        end
    endtask

    task automatic run_rounds(input int first, input int last, input int bad_at, input bit abc);
        for (int t = first; t <= last; t++) begin
            @(negedge clk);
            round_en  = 1'b1;
            round_idx = (t == bad_at) ? 6'(t + 1) : 6'(t);
            exp_q.push_back(w_gold[t]);
            #1;
            check("w_valid_round", {31'b0, w_valid}, 32'd1);
            if (w_valid) begin
                if (exp_q.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
                else                   check("w_out_round", w_out, exp_q.pop_front());
            end
            if (abc && t == 15) check("abc_w15", w_out, 32'h00000018);
            if (abc && t == 16) check("abc_w16", w_out, 32'h61626380);
            if (abc && t == 17) check("abc_w17", w_out, 32'h000F0000);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load_ready"},   {31'b0, load_ready},   32'd1);
        check({tag, "_block_loaded"}, {31'b0, block_loaded}, 32'd0);
        check({tag, "_w_out"},        w_out,                 32'd0);
        check({tag, "_w_valid"},      {31'b0, w_valid},      32'd0);
        check({tag, "_seq_err"},      {31'b0, seq_err},      32'd0);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        round_en = 1'b0; round_idx = 6'd0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rstn = 1'b1;

        // "abc" block: single block_loaded pulse one cycle after byte 64
        set_abc();
        pulses = 0;
        load_bytes(64);
        @(negedge clk);
        byte_valid = 1'b0;
        #1;
        check("abc_block_loaded", {31'b0, block_loaded}, 32'd1);
        check("abc_load_ready_full", {31'b0, load_ready}, 32'd0);
        check("abc_w0", w_out, 32'h61626380);
        @(negedge clk);
        #1;
        check("abc_pulse_one_cycle", {31'b0, block_loaded}, 32'd0);
        check("abc_no_early_pulse", 32'(pulses), 32'd0);

        // Rounds with a 3-cycle stall at round 20
        run_rounds(0, 19, -1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            round_en = 1'b0;
            #1;
            check("stall_w_valid", {31'b0, w_valid}, 32'd0);
            check("stall_w_out_holds", w_out, w_gold[20]);
        end
        run_rounds(20, 63, -1, 1'b0);
        @(negedge clk);
        round_en = 1'b0;
        #1;
        check("after_r63_load_ready", {31'b0, load_ready}, 32'd1);
        check("after_r63_w_valid", {31'b0, w_valid}, 32'd0);
        check("after_r63_seq_err", {31'b0, seq_err}, 32'd0);

        // flush after 30 bytes leaves a half-built word behind
        set_rand();
        load_bytes(30);
        @(negedge clk);
        byte_valid = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_load_ready", {31'b0, load_ready}, 32'd1);
        check("flush_no_pulse", {31'b0, block_loaded}, 32'd0);
        load_bytes(64);
        @(negedge clk);
        byte_valid = 1'b0;
        #1;
        check("reload_block_loaded", {31'b0, block_loaded}, 32'd1);
        check("reload_w0", w_out, w_gold[0]);

        // Desync at round 4 (round_idx=5), full block still delivered
        run_rounds(0, 63, 4, 1'b0);
        @(negedge clk);
        round_en = 1'b0;
        #1;
        check("desync_seq_err", {31'b0, seq_err}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("seq_err_survives_flush", {31'b0, seq_err}, 32'd1);

        // flush coincident with the 64th byte: no pulse, back to IDLE
        set_abc();
        load_bytes(63);
        @(negedge clk);
        byte_in    = msg[63];
        byte_valid = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        flush      = 1'b0;
        #1;
        check("flush64_no_pulse", {31'b0, block_loaded}, 32'd0);
        check("flush64_load_ready", {31'b0, load_ready}, 32'd1);

        // Next block: seq_err stays sticky, bytes during ROUND are dropped
        load_bytes(64);
        @(negedge clk);
        byte_valid = 1'b0;
        #1;
        check("blk3_block_loaded", {31'b0, block_loaded}, 32'd1);
        check("blk3_seq_err_sticky", {31'b0, seq_err}, 32'd1);
        run_rounds(0, 9, -1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            round_en   = 1'b0;
            byte_valid = 1'b1;
            byte_in    = 8'hA5 + 8'(i);
            #1;
            check("round_byte_load_ready", {31'b0, load_ready}, 32'd0);
            check("round_byte_w_out", w_out, w_gold[10]);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        #1;
        check("round_bytes_ignored", w_out, w_gold[10]);
        run_rounds(10, 20, -1, 1'b1);

        // Asynchronous reset mid-round
        @(negedge clk);
        round_en  = 1'b1;
        round_idx = 6'd21;
        rstn      = 1'b0;
        #1;
        check_reset_values("midround_reset");
        @(negedge clk);
        round_en = 1'b0;
        rstn     = 1'b1;

        // round_en in IDLE is ignored but flagged
        @(negedge clk);
        round_en  = 1'b1;
        round_idx = 6'd0;
        #1;
        check("idle_round_w_valid", {31'b0, w_valid}, 32'd0);
        @(negedge clk);
        round_en = 1'b0;
        #1;
        check("idle_round_seq_err", {31'b0, seq_err}, 32'd1);
        check("idle_round_load_ready", {31'b0, load_ready}, 32'd1);
        check("idle_round_w_out", w_out, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha_msg_schedule.md
Name: sha_msg_schedule

Overview:
- Upstream/companion stage to the SHA-256 round controller.
- Accepts one pre-padded 512-bit message block byte-serially from the 8-bit pin interface and holds it in a 16-word sliding window.
- While the controller runs phase 1, presents W[t] for t = 0..63, one word per round cycle, to the round datapath.
- Signals when a full block has been loaded so the top level can pulse the controller's start.

Parameters:
- ERR_CHECK, 1, when 1, compare round_idx against the internal round counter and set seq_err on mismatch; when 0, seq_err is tied 0.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- byte_in  in  8  message byte, big-endian within each word.
- byte_valid  in  1  byte_in valid this cycle.
- load_ready  out  1  block can accept a byte.
- block_loaded  out  1  one-cycle pulse when all 64 bytes are held.
- round_en  in  1  round advance; driven from the controller's phase-1 running flag.
- round_idx  in  6  controller phase-1 round counter.
- w_out  out  32  W[t] for the current round (combinational from window[0]).
- w_valid  out  1  high in ROUND state while round_en=1.
- seq_err  out  1  sticky; round_idx/counter mismatch, or round_en outside FULL/ROUND.

Behaviour:
- Reset: asynchronous on rstn low. State=IDLE, byte_cnt=0, rnd_cnt=0, window and accumulator cleared. Output reset values: load_ready=1, block_loaded=0, w_out=0, w_valid=0, seq_err=0.
- States: IDLE, LOAD, FULL, ROUND.
- Byte accept: byte is accepted when byte_valid && load_ready. load_ready=1 only in IDLE and LOAD.
- Accumulator: each accepted byte shifts into a 32-bit accumulator, MSB first (acc = {acc[23:0], byte_in}).
- Word commit: on every 4th accepted byte, the completed word shifts into the window. window[15] receives the new word; all entries shift down by one. After 16 words, window[0]=W0 and window[15]=W15.
- IDLE→LOAD: on the first accepted byte.
- LOAD→FULL: on the 64th accepted byte (byte_cnt wraps 63→0). block_loaded is a 1-cycle pulse in the first cycle of FULL. load_ready=0 in that same cycle.
- FULL→ROUND: in the first cycle with round_en=1. That cycle is round 0, rnd_cnt=0.
- ROUND, each cycle with round_en=1:
  - w_out=window[0]=W[t], w_valid=1.
  - Window shifts down one entry; window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3. sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - rnd_cnt increments.
- ROUND with round_en=0: stall. No shift, w_valid=0, w_out still shows window[0].
- ROUND→IDLE: on the cycle with round_en=1 and rnd_cnt=63 (64 words presented). rnd_cnt wraps to 0, load_ready=1 on the next cycle.
- Pipelined reload: not supported. Bytes arriving in FULL/ROUND are dropped; load_ready=0 tells the source to wait.
- seq_err (ERR_CHECK=1): set when round_en=1 && state==ROUND && round_idx!=rnd_cnt. Also set when round_en=1 in IDLE or LOAD; the schedule ignores that round_en. Cleared only by rstn; flush does not clear it.
- flush: highest priority over byte accept and round advance. Next cycle: IDLE, byte_cnt=0, rnd_cnt=0, accumulator cleared. Window contents are don't-care; w_valid=0.
- Simultaneous flush and 64th byte: flush wins, no block_loaded pulse.
- Reset mid-ROUND: immediate return to the reset values listed above.
- Padding is upstream's responsibility; the block treats the 64 bytes as opaque data.

Decomposition:
- Shared package sha_pkg: sha256 word typedef (logic [31:0]), state enum, sigma0/sigma1 functions, constants WORDS_PER_BLOCK=16, BYTES_PER_BLOCK=64, ROUNDS=64.
- One sub-module: sha_byte_packer (byte accumulator plus 2-bit byte counter emitting word_valid/word). The window and FSM stay in the top.

Test Plan:
- "abc" block: bytes 61 62 63 80, 59×00, 18 → block_loaded pulses exactly once, one cycle after the 64th byte. Then W0=0x61626380, W1..W14=0, W15=0x00000018.
- Same block, round_en high for 64 cycles with round_idx 0..63 → W16=0x61626380, W17=0x000F0000. All 64 words match the golden model; load_ready=1 the cycle after round 63; seq_err=0.
- Stall: drop round_en for 3 cycles at round 20 → w_out holds W20, w_valid=0, no counter advance; sequence resumes with W20.
- Desync: round_idx=5 while rnd_cnt=4 → seq_err=1 and stays 1 through the next block; only rstn clears it.
- flush after 30 bytes → next cycle IDLE, load_ready=1. A fresh 64-byte load then produces correct W0 (no stale partial word).
- byte_valid pulses during ROUND and round_en pulses in IDLE → bytes ignored (window unchanged), seq_err=1. rstn low mid-round → all outputs return to their reset values asynchronously.
